// File: rtl/rr_mux_if.sv
// Shared-channel bundle for the round-robin mux arbiter: requester side,
// downstream channel and grant status.
interface rr_mux_if #(
  parameter int N_REQ = 4,
  parameter int W     = 8
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               out_valid;
  logic [W-1:0]       out_data;
  logic               out_ready;
  logic [N_REQ-1:0]   grant;
  logic               busy;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, grant, busy
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, grant, busy
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one N:1 data mux between N_REQ valid/ready
// requesters; the registered grant is held for up to BURST_LEN transfers.
module rr_mux_arbiter #(
  parameter int N_REQ     = 4,
  parameter int W         = 8,
  parameter int BURST_LEN = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  rr_mux_if.slave  bus
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_q,  last_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic [IDX_W-1:0]   g_idx;
  logic [W-1:0]       out_data_c;
  logic               out_valid_c;
  logic               xfer;
  logic               rearb;
  logic [N_REQ-1:0]   others;

  // First valid requester scanning p+1, p+2, ... wrapping; p itself is last.
  function automatic logic [IDX_W-1:0] pick(input logic [IDX_W-1:0] p,
                                            input logic [N_REQ-1:0] v);
    logic [IDX_W-1:0] r;
    logic             found;
    int               j;
    r     = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(p) + k) % N_REQ;
      if (!found && v[IDX_W'(j)]) begin
        r     = IDX_W'(j);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  always_comb begin
    out_data_c = '0;
    g_idx      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        out_data_c = out_data_c | bus.req_data[i*W +: W];
        g_idx      = IDX_W'(i);
      end
    end
  end

  assign out_valid_c   = |(grant_q & bus.req_valid);
  assign xfer          = out_valid_c & bus.out_ready;
  assign others        = bus.req_valid & ~grant_q;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_c;
  assign bus.req_ready = grant_q & {N_REQ{bus.out_ready}};
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rearb   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          grant_d = onehot(pick(last_q, bus.req_valid));
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (xfer) begin
          if (int'(cnt_q) + 1 < BURST_LEN) cnt_d = cnt_q + CNT_W'(1);
          else                             rearb = 1'b1;
        end else if (!out_valid_c) begin
          rearb = 1'b1;
        end
        // Burst done or owner withdrew: hand over without a bubble if anyone else waits.
        if (rearb) begin
          last_d = g_idx;
          cnt_d  = '0;
          if (|others) begin
            grant_d = onehot(pick(g_idx, others));
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: one instance with single-transfer
// grants and one with four-transfer bursts.
module tb_rr_mux_arbiter;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  rr_mux_if #(.N_REQ(4), .W(8)) bus1();
  rr_mux_if #(.N_REQ(4), .W(8)) bus4();

  rr_mux_arbiter #(.N_REQ(4), .W(8), .BURST_LEN(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  rr_mux_arbiter #(.N_REQ(4), .W(8), .BURST_LEN(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  // Requester i presents {i, sequence number}; the sequence advances per accepted beat.
  logic [5:0] seq1 [4];
  logic [5:0] seq4 [4];
  assign bus1.req_data = {2'd3, seq1[3], 2'd2, seq1[2], 2'd1, seq1[1], 2'd0, seq1[0]};
  assign bus4.req_data = {2'd3, seq4[3], 2'd2, seq4[2], 2'd1, seq4[1], 2'd0, seq4[0]};

  logic [7:0] q1 [$];
  logic [7:0] q4 [$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] dat(input int i, input int s);
    logic [31:0] a;
    logic [31:0] b;
    a = i;
    b = s;
    return {a[1:0], b[5:0]};
  endfunction

  function automatic int idx_of(input logic [3:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // Sample the upcoming transfer, cross the active edge, then advance requester data.
  task automatic step();
    logic x1, x4;
    int   a1, a4;
    a1 = 0;
    a4 = 0;
    #1;
    x1 = bus1.out_valid && bus1.out_ready;
    x4 = bus4.out_valid && bus4.out_ready;
    if (x1) begin
      chk("sb1_pending", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) chk("sb1_data", 32'(bus1.out_data), 32'(q1.pop_front()));
      a1 = idx_of(bus1.req_ready);
    end
    if (x4) begin
      chk("sb4_pending", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) chk("sb4_data", 32'(bus4.out_data), 32'(q4.pop_front()));
      a4 = idx_of(bus4.req_ready);
    end
    @(posedge clk);
    #1;
    if (x1) seq1[a1] = seq1[a1] + 6'd1;
    if (x4) seq4[a4] = seq4[a4] + 6'd1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    bus1.req_valid = '0;
    bus1.out_ready = 1'b0;
    bus4.req_valid = '0;
    bus4.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seq1[i] = '0;
      seq4[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(bus1.grant), 32'd0);
    chk("rst_valid", 32'(bus1.out_valid), 32'd0);
    chk("rst_busy",  32'(bus1.busy), 32'd0);
    chk("rst_data",  32'(bus1.out_data), 32'd0);
    rst_n = 1'b1;
    step();

    // Round-robin rotation with every requester valid.
    bus1.req_valid = 4'hF;
    bus1.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) q1.push_back(dat(k % 4, k / 4));
    step();
    chk("t2_busy", 32'(bus1.busy), 32'd1);
    for (int k = 0; k < 8; k++) begin
      chk("t2_grant", 32'(bus1.grant), 32'(1 << (k % 4)));
      step();
    end
    bus1.req_valid = '0;
    step();
    step();
    chk("t2_drain", 32'(q1.size()), 32'd0);
    chk("t2_idle",  32'(bus1.grant), 32'd0);

    // Back-pressure on a sole requester, then the mandatory idle bubble.
    seq1[2]        = 6'h25;
    bus1.out_ready = 1'b0;
    bus1.req_valid = 4'b0100;
    step();
    for (int k = 0; k < 3; k++) begin
      chk("t3_grant", 32'(bus1.grant), 32'h4);
      chk("t3_data",  32'(bus1.out_data), 32'hA5);
      chk("t3_ready", 32'(bus1.req_ready), 32'h0);
      chk("t3_valid", 32'(bus1.out_valid), 32'd1);
      step();
    end
    bus1.out_ready = 1'b1;
    q1.push_back(8'hA5);
    step();
    chk("t3_bubble", 32'(bus1.grant), 32'd0);
    chk("t3_bubble_busy", 32'(bus1.busy), 32'd0);
    step();
    chk("t3_regrant", 32'(bus1.grant), 32'h4);
    chk("t3_next_data", 32'(bus1.out_data), 32'hA6);
    bus1.req_valid = '0;
    step();
    step();

    // Granted requester withdraws before ready; grant moves on without a transfer.
    bus1.out_ready = 1'b0;
    bus1.req_valid = 4'b0010;
    step();
    chk("t5_grant1", 32'(bus1.grant), 32'h2);
    bus1.req_valid = 4'b1000;
    step();
    chk("t5_grant3",  32'(bus1.grant), 32'h8);
    chk("t5_valid",   32'(bus1.out_valid), 32'd1);
    chk("t5_no_xfer", 32'(seq1[1]), 32'd2);
    bus1.out_ready = 1'b1;
    q1.push_back(dat(3, seq1[3]));
    step();
    bus1.req_valid = '0;
    step();
    chk("t5_idle", 32'(bus1.grant), 32'd0);

    // Four-beat bursts alternate between two requesters with no bubble.
    bus4.req_valid = 4'b0011;
    bus4.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) q4.push_back(dat(0, k));
    for (int k = 0; k < 4; k++) q4.push_back(dat(1, k));
    step();
    for (int k = 0; k < 8; k++) begin
      chk("t4_grant", 32'(bus4.grant), (k < 4) ? 32'h1 : 32'h2);
      if (k == 4) chk("t4_busy", 32'(bus4.busy), 32'd1);
      step();
    end
    chk("t4_wrap", 32'(bus4.grant), 32'h1);
    bus4.req_valid = '0;
    step();
    step();
    chk("t4_drain", 32'(q4.size()), 32'd0);

    // Asynchronous reset in the middle of a held grant.
    bus1.out_ready = 1'b0;
    bus1.req_valid = 4'b0010;
    step();
    chk("t1_grant1", 32'(bus1.grant), 32'h2);
    bus1.out_ready = 1'b1;
    q1.push_back(dat(1, seq1[1]));
    step();
    bus1.req_valid = 4'b0100;
    bus1.out_ready = 1'b0;
    step();
    chk("t1_grant2", 32'(bus1.grant), 32'h4);
    bus1.out_ready = 1'b1;
    #2;
    chk("t1_pre_ready", 32'(bus1.req_ready), 32'h4);
    rst_n = 1'b0;
    #1;
    chk("t1_grant",    32'(bus1.grant), 32'd0);
    chk("t1_valid",    32'(bus1.out_valid), 32'd0);
    chk("t1_ready",    32'(bus1.req_ready), 32'd0);
    chk("t1_data",     32'(bus1.out_data), 32'd0);
    chk("t1_busy",     32'(bus1.busy), 32'd0);
    bus1.req_valid = 4'b0101;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t1_first", 32'(bus1.grant), 32'h1);
    q1.push_back(dat(0, seq1[0]));
    step();
    chk("t1_second", 32'(bus1.grant), 32'h4);
    bus1.req_valid = '0;
    step();
    step();

    // Long idle stretch.
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t6_busy",  32'(bus1.busy), 32'd0);
      chk("t6_grant", 32'(bus1.grant), 32'd0);
      chk("t6_valid", 32'(bus1.out_valid), 32'd0);
      chk("t6_data",  32'(bus1.out_data), 32'd0);
    end
    chk("t6_grant4", 32'(bus4.grant), 32'd0);
    chk("end_q1", 32'(q1.size()), 32'd0);
    chk("end_q4", 32'(q4.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
